// File: rtl/if_stage_fetch_if.sv
// if_stage_fetch_if: bundles the instruction-ROM port and the IF/ID outputs of
// the fetch stage. The master side is the fetch stage; the slave side is the
// ROM plus the decode stage that consumes IF/ID.
interface if_stage_fetch_if;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_pred_taken;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        output if_id_valid,
        output if_id_inst,
        output if_id_pc,
        output if_id_pc4,
        output if_id_pred_taken
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        input  if_id_valid,
        input  if_id_inst,
        input  if_id_pc,
        input  if_id_pc4,
        input  if_id_pred_taken
    );
endinterface

// File: rtl/if_stage_fetch.sv
// if_stage_fetch: instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, drives a 1-cycle-latency instruction ROM, and uses a 1-entry
// skid buffer so a decode stall never loses the read already in flight.
// Redirects from EX flush everything in the stage.
// Optional: define IF_JAL_PREDICT_EN to predecode JAL in IF/ID and redirect
// fetch to its target at the cost of one bubble.
module if_stage_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_d,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    if_stage_fetch_if.master fetch
);

    logic [31:0] pc_f;
    logic        req_v;
    logic [31:0] req_pc;
    logic        skid_v;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;

    logic        if_id_valid_q;
    logic [31:0] if_id_inst_q;
    logic [31:0] if_id_pc_q;
    logic [31:0] if_id_pc4_q;
    logic        if_id_pred_q;

    logic        load_v;
    logic [31:0] load_inst;
    logic [31:0] load_pc;
    logic        jal_take;
    logic        issue;

    // Candidate for IF/ID this cycle: the skid entry is older, so it goes first.
    always_comb begin
        load_v    = 1'b0;
        load_inst = NOP_INST;
        load_pc   = req_pc;
        if (skid_v) begin
            load_v    = 1'b1;
            load_inst = skid_inst;
            load_pc   = skid_pc;
        end else if (req_v) begin
            load_v    = 1'b1;
            load_inst = fetch.imem_rdata;
            load_pc   = req_pc;
        end
    end

`ifdef IF_JAL_PREDICT_EN
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    logic [31:0] jal_imm;
    logic [31:0] jal_target;

    assign jal_imm    = {{12{load_inst[31]}}, load_inst[19:12], load_inst[20],
                         load_inst[30:21], 1'b0};
    assign jal_target = load_pc + jal_imm;
    assign jal_take   = !reset && !redirect_valid && !stall_d && load_v &&
                        (load_inst[6:0] == OPC_JAL);
`else
    assign jal_take = 1'b0;
`endif

    // A new read may start unless a flush is pending, the skid would overflow,
    // or a predicted JAL is about to retarget the PC.
    assign issue = !reset && !redirect_valid && !(stall_d && (req_v || skid_v)) && !jal_take;

    assign fetch.imem_en          = issue;
    assign fetch.imem_addr        = pc_f;
    assign fetch.if_id_valid      = if_id_valid_q;
    assign fetch.if_id_inst       = if_id_inst_q;
    assign fetch.if_id_pc         = if_id_pc_q;
    assign fetch.if_id_pc4        = if_id_pc4_q;
    assign fetch.if_id_pred_taken = if_id_pred_q;

    // PC, in-flight read, skid buffer and IF/ID register; reset beats redirect,
    // redirect beats stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f          <= PC_RESET;
            req_v         <= 1'b0;
            req_pc        <= PC_RESET;
            skid_v        <= 1'b0;
            skid_inst     <= NOP_INST;
            skid_pc       <= PC_RESET;
            if_id_valid_q <= 1'b0;
            if_id_inst_q  <= NOP_INST;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_pc4_q   <= 32'h0000_0004;
            if_id_pred_q  <= 1'b0;
        end else if (redirect_valid) begin
            pc_f          <= redirect_pc;
            req_v         <= 1'b0;
            skid_v        <= 1'b0;
            if_id_valid_q <= 1'b0;
            if_id_inst_q  <= NOP_INST;
            if_id_pred_q  <= 1'b0;
        end else begin
            req_v <= issue;
            if (issue) begin
                req_pc <= pc_f;
                pc_f   <= pc_f + 32'd4;
            end
            if (!stall_d) begin
                skid_v <= 1'b0;
                if (load_v) begin
                    if_id_valid_q <= 1'b1;
                    if_id_inst_q  <= load_inst;
                    if_id_pc_q    <= load_pc;
                    if_id_pc4_q   <= load_pc + 32'd4;
                    if_id_pred_q  <= jal_take;
                end else begin
                    if_id_valid_q <= 1'b0;
                    if_id_inst_q  <= NOP_INST;
                    if_id_pred_q  <= 1'b0;
                end
`ifdef IF_JAL_PREDICT_EN
                if (jal_take) begin
                    pc_f <= jal_target;
                end
`endif
            end else if (req_v) begin
                skid_v    <= 1'b1;
                skid_inst <= fetch.imem_rdata;
                skid_pc   <= req_pc;
            end
        end
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// tb_if_stage_fetch: scoreboard bench for if_stage_fetch. The stimulus side
// drives stalls, redirects and resets and refills an expected program-order
// stream whenever the PC is retargeted; a monitor pops that stream each time
// IF/ID accepts a live instruction.
module tb_if_stage_fetch;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_d = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int compared = 0;
    int mismatched = 0;
    int pops = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } exp_t;

    exp_t expQ[$];

    if_stage_fetch_if bus();

    if_stage_fetch #(
        .PC_RESET(PC_RESET),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall_d(stall_d),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .fetch(bus)
    );

    always #5 clk = ~clk;

    // ROM image: word n holds n, except a JAL (+8) at 0x20; other words are
    // kept clear of the JAL opcode.
    function automatic logic [31:0] romWord(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        if (a == 32'h20) return 32'h008000EF;
        if (w[6:0] == 7'b1101111) w[0] = 1'b0;
        return w;
    endfunction

    // J-type offset: sign bit, then bits 19:12, 11, 10:1.
    function automatic logic [31:0] jOffset(input logic [31:0] i);
        logic [31:0] off;
        off = 32'h0;
        off[20]    = i[31];
        off[19:12] = i[19:12];
        off[11]    = i[20];
        off[10:1]  = i[30:21];
        if (i[31]) off[31:21] = 11'h7FF;
        return off;
    endfunction

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= romWord(bus.imem_addr);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Program-order stream starting at a new fetch target.
    task automatic rebuildStream(input logic [31:0] start);
        logic [31:0] pc;
        exp_t e;
        pc = start;
        expQ.delete();
        for (int n = 0; n < 48; n++) begin
            e.pc   = pc;
            e.inst = romWord(pc);
`ifdef IF_JAL_PREDICT_EN
            e.pred = (e.inst[6:0] == 7'b1101111);
`else
            e.pred = 1'b0;
`endif
            expQ.push_back(e);
            pc = e.pred ? (pc + jOffset(e.inst)) : (pc + 32'd4);
        end
    endtask

    task automatic applyStimulus(input logic rs, input logic st, input logic rv,
                                 input logic [31:0] rp);
        @(posedge clk);
        if (reset) rebuildStream(PC_RESET);
        else if (redirect_valid) rebuildStream(redirect_pc);
        #1;
        reset          = rs;
        stall_d        = st;
        redirect_valid = rv;
        redirect_pc    = rp;
    endtask

    task automatic stepCheck(input logic st, input logic expValid, input logic [31:0] expPc);
        applyStimulus(1'b0, st, 1'b0, 32'h0);
        #1;
        checkOutput("dirValid", 32'(bus.if_id_valid), 32'(expValid));
        if (expValid) checkOutput("dirPc", bus.if_id_pc, expPc);
    endtask

    // Monitor: classify each cycle by the controls seen at the edge, then
    // compare IF/ID against the scoreboard.
    initial begin : monitor
        logic prevStall, prevRedir, prevRst;
        exp_t e;
        exp_t lastExp;
        logic lastExpValid;
        int idle;
        lastExpValid = 1'b0;
        idle = 0;
        lastExp = '0;
        forever begin
            @(posedge clk);
            prevStall = stall_d;
            prevRedir = redirect_valid;
            prevRst   = reset;
            @(negedge clk);
            if (prevRst || prevRedir) begin
                checkOutput("flushValid", 32'(bus.if_id_valid), 32'h0);
                checkOutput("flushInst", bus.if_id_inst, NOP_INST);
                lastExpValid = 1'b0;
                idle = 0;
            end else if (prevStall) begin
                checkOutput("holdValid", 32'(bus.if_id_valid), 32'(lastExpValid));
                if (lastExpValid) begin
                    checkOutput("holdPc", bus.if_id_pc, lastExp.pc);
                    checkOutput("holdInst", bus.if_id_inst, lastExp.inst);
                end
                idle++;
            end else if (bus.if_id_valid) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL sbEmpty: got pc %h, expected no instruction", bus.if_id_pc);
                    lastExpValid = 1'b0;
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sbPc", bus.if_id_pc, e.pc);
                    checkOutput("sbInst", bus.if_id_inst, e.inst);
                    checkOutput("sbPc4", bus.if_id_pc4, e.pc + 32'd4);
                    checkOutput("sbPred", 32'(bus.if_id_pred_taken), 32'(e.pred));
                    lastExp = e;
                    lastExpValid = 1'b1;
                    pops++;
                end
                idle = 0;
            end else begin
                checkOutput("bubbleInst", bus.if_id_inst, NOP_INST);
                lastExpValid = 1'b0;
                idle++;
            end
            if (idle > 40) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL liveness: got %0d idle cycles, expected at most 40", idle);
                idle = 0;
            end
        end
    end

    // Directed scenarios followed by a randomized stall/redirect/reset run.
    initial begin : stimulus
        logic st, rv, rs;
        logic [31:0] rp;
        int sinceRedir;

        // Held in reset: no ROM reads.
        repeat (3) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            #1;
            checkOutput("rstEn", 32'(bus.imem_en), 32'h0);
        end

        // Reset release: fetch PC_RESET immediately, first valid two cycles later.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("relEn", 32'(bus.imem_en), 32'h1);
        checkOutput("relAddr", bus.imem_addr, PC_RESET);
        checkOutput("relPc", bus.if_id_pc, 32'h0);
        checkOutput("relPc4", bus.if_id_pc4, 32'h4);
        checkOutput("relInst", bus.if_id_inst, NOP_INST);
        stepCheck(1'b0, 1'b0, 32'h0);
        stepCheck(1'b0, 1'b1, 32'h0);
        checkOutput("firstInst", bus.if_id_inst, 32'h0);
        stepCheck(1'b0, 1'b1, 32'h4);
        checkOutput("secondInst", bus.if_id_inst, 32'h1);
        stepCheck(1'b0, 1'b1, 32'h8);
        stepCheck(1'b0, 1'b1, 32'hC);

        // Three-cycle stall while 0x10 sits in IF/ID.
        stepCheck(1'b1, 1'b1, 32'h10);
        stepCheck(1'b1, 1'b1, 32'h10);
        stepCheck(1'b1, 1'b1, 32'h10);
        stepCheck(1'b0, 1'b1, 32'h10);
        stepCheck(1'b0, 1'b1, 32'h14);
        stepCheck(1'b0, 1'b1, 32'h18);
        stepCheck(1'b0, 1'b1, 32'h1C);
        stepCheck(1'b0, 1'b1, 32'h20);
`ifdef IF_JAL_PREDICT_EN
        checkOutput("jalPred", 32'(bus.if_id_pred_taken), 32'h1);
        stepCheck(1'b0, 1'b0, 32'h0);
        stepCheck(1'b0, 1'b1, 32'h28);
`else
        checkOutput("jalPred", 32'(bus.if_id_pred_taken), 32'h0);
        stepCheck(1'b0, 1'b1, 32'h24);
        stepCheck(1'b0, 1'b1, 32'h28);
`endif

        // Redirect to 0x100: two bubbles, target valid three cycles later.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
        stepCheck(1'b0, 1'b0, 32'h0);
        checkOutput("redirAddr", bus.imem_addr, 32'h100);
        stepCheck(1'b0, 1'b0, 32'h0);
        stepCheck(1'b0, 1'b1, 32'h100);
        stepCheck(1'b0, 1'b1, 32'h104);

        // Fill the skid under stall, then redirect while still stalled.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
        stepCheck(1'b0, 1'b0, 32'h0);
        stepCheck(1'b0, 1'b0, 32'h0);
        stepCheck(1'b0, 1'b1, 32'h200);

        // Fetch address wraps from 0xFFFF_FFFC to 0.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        stepCheck(1'b0, 1'b0, 32'h0);
        checkOutput("wrapAddr0", bus.imem_addr, 32'hFFFF_FFF8);
        stepCheck(1'b0, 1'b0, 32'h0);
        checkOutput("wrapAddr1", bus.imem_addr, 32'hFFFF_FFFC);
        stepCheck(1'b0, 1'b1, 32'hFFFF_FFF8);
        checkOutput("wrapAddr2", bus.imem_addr, 32'h0);
        stepCheck(1'b0, 1'b1, 32'hFFFF_FFFC);
        stepCheck(1'b0, 1'b1, 32'h0);

        // Reset asserted together with stall and redirect dominates both.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h300);
        #1;
        checkOutput("rstDomEn", 32'(bus.imem_en), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("rstDomAddr", bus.imem_addr, PC_RESET);
        stepCheck(1'b0, 1'b0, 32'h0);
        stepCheck(1'b0, 1'b1, PC_RESET);

        // Randomized run; the monitor checks order against the scoreboard.
        sinceRedir = 0;
        for (int c = 0; c < 1500; c++) begin
            st = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 99) == 0);
            rv = ($urandom_range(0, 15) == 0) || (sinceRedir >= 25);
            rp = $urandom & 32'h0000_03FC;
            if ($urandom_range(0, 7) == 0) rp = $urandom & 32'hFFFF_FFFC;
            sinceRedir = (rv || rs) ? 0 : sinceRedir + 1;
            applyStimulus(rs, st, rv, rp);
        end
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        checkOutput("popsSeen", 32'(pops > 300), 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
